memwb_pipe_reg: RTL and testbench

Parametrised MEM→WB pipeline register with a valid/ready handshake, flush, x0-write suppression and a saturating stall counter. It sits between the data-memory stage and the register-file write-back mux. It replaces the free-running MEM/WB register so that back-pressure from write-back, such as a multi-cycle writer, can stall the pipe without losing beats.

---
 rtl/memwb_pkg.sv | 21 ++
 rtl/memwb_stall_cnt.sv | 13 +
 rtl/memwb_pipe_reg.sv | 96 +++++++++
 tb/tb_memwb_pipe_reg.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/memwb_pkg.sv
// memwb_pkg: shared types and default widths for the MEM->WB pipeline register.
package memwb_pkg;
  localparam int MEMWB_WIDTH        = 32;
  localparam int MEMWB_REG_ADDR_W   = 5;
  localparam int MEMWB_RESULT_SRC_W = 2;
  localparam int MEMWB_CNT_W        = 16;
  typedef struct packed {
    logic                          reg_write;
    logic [MEMWB_RESULT_SRC_W-1:0] result_src;
    logic [MEMWB_WIDTH-1:0]        read_data;
    logic [MEMWB_WIDTH-1:0]        alu_result;
    logic [MEMWB_REG_ADDR_W-1:0]   rd;
    logic [MEMWB_WIDTH-1:0]        pc_plus4;
    logic [MEMWB_WIDTH-1:0]        imm_ext;
  } memwb_payload_t;
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HEAD  = 2'd1,
    FULL  = 2'd2
  } memwb_state_e;
endpackage

// File: rtl/memwb_stall_cnt.sv
// memwb_stall_cnt: saturating stall-cycle counter shared by the stage registers.
module memwb_stall_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (inc && !(&count)) count <= count + 1'b1;
endmodule

// File: rtl/memwb_pipe_reg.sv
// memwb_pipe_reg: MEM->WB register with valid/ready handshake, flush and stall counter.
// Define MEMWB_SKID_EN for the two-entry skid variant with a registered ReadyM.
module memwb_pipe_reg
  import memwb_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int REG_ADDR_W   = 5,
  parameter int RESULT_SRC_W = 2,
  parameter int CNT_W        = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ValidM,
  output logic                    ReadyM,
  input  logic                    RegWriteM,
  input  logic [RESULT_SRC_W-1:0] ResultSrcM,
  input  logic [WIDTH-1:0]        ReadDataM,
  input  logic [WIDTH-1:0]        ALUResultM,
  input  logic [REG_ADDR_W-1:0]   RdM,
  input  logic [WIDTH-1:0]        PCPlus4M,
  input  logic [WIDTH-1:0]        ImmExtM,
  input  logic                    FlushW,
  output logic                    ValidW,
  input  logic                    ReadyW,
  output logic                    RegWriteW,
  output logic [RESULT_SRC_W-1:0] ResultSrcW,
  output logic [WIDTH-1:0]        ReadDataW,
  output logic [WIDTH-1:0]        ALUResultW,
  output logic [REG_ADDR_W-1:0]   RdW,
  output logic [WIDTH-1:0]        PCPlus4W,
  output logic [WIDTH-1:0]        ImmExtW,
  output logic [CNT_W-1:0]        StallCount
);
  localparam int PW = 1 + RESULT_SRC_W + 4 * WIDTH + REG_ADDR_W;
  memwb_state_e  state, state_next;
  logic [PW-1:0] in_pl, main_q, main_d;
  logic          acc, del, reg_write_q;
  assign in_pl  = {RegWriteM, ResultSrcM, ReadDataM, ALUResultM, RdM, PCPlus4M, ImmExtM};
  assign ValidW = state != EMPTY;
  assign acc    = ValidM && ReadyM;
  assign del    = ValidW && ReadyW;
`ifdef MEMWB_SKID_EN
  logic [PW-1:0] skid_q, skid_d;
  // ReadyM decodes registered state only, so WB back-pressure never reaches MEM combinationally.
  assign ReadyM = state != FULL;
  always_comb begin
    state_next = state;
    main_d     = main_q;
    skid_d     = skid_q;
    case (state)
      EMPTY: if (acc) begin
        state_next = HEAD;
        main_d     = in_pl;
      end
      HEAD: if (acc && del) main_d = in_pl;
      else if (acc) begin
        state_next = FULL;
        skid_d     = in_pl;
      end
      else if (del) state_next = EMPTY;
      FULL: if (del) begin
        state_next = HEAD;
        main_d     = skid_q;
      end
      default: state_next = EMPTY;
    endcase
    if (FlushW) state_next = EMPTY;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) skid_q <= '0;
    else skid_q <= skid_d;
`else
  assign ReadyM = !ValidW || ReadyW;
  always_comb begin
    state_next = FlushW ? EMPTY : acc ? HEAD : del ? EMPTY : state;
    main_d     = acc ? in_pl : main_q;
  end
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= EMPTY;
      main_q <= '0;
    end else begin
      state  <= state_next;
      main_q <= main_d;
    end
  assign {reg_write_q, ResultSrcW, ReadDataW, ALUResultW, RdW, PCPlus4W, ImmExtW} = main_q;
  // Bubbles and x0 destinations must never produce a register-file write.
  assign RegWriteW = reg_write_q && ValidW && (RdW != '0);
  memwb_stall_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (ValidW && !ReadyW),
    .count(StallCount)
  );
endmodule

// File: tb/tb_memwb_pipe_reg.sv
// tb_memwb_pipe_reg: directed checks of memwb_pipe_reg (CNT_W=4), covering both
// the default single-entry build and the MEMWB_SKID_EN build.
module tb_memwb_pipe_reg;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        ValidM = 1'b0, ReadyM, RegWriteM = 1'b0, FlushW = 1'b0, ValidW, ReadyW = 1'b0;
  logic [1:0]  ResultSrcM = '0, ResultSrcW;
  logic [31:0] ReadDataM = '0, ALUResultM = '0, PCPlus4M = '0, ImmExtM = '0;
  logic [31:0] ReadDataW, ALUResultW, PCPlus4W, ImmExtW;
  logic [4:0]  RdM = '0, RdW;
  logic        RegWriteW;
  logic [3:0]  StallCount;
  int          checks = 0, errors = 0;

  memwb_pipe_reg #(.CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .ValidM(ValidM), .ReadyM(ReadyM),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .ReadDataM(ReadDataM),
    .ALUResultM(ALUResultM), .RdM(RdM), .PCPlus4M(PCPlus4M), .ImmExtM(ImmExtM),
    .FlushW(FlushW), .ValidW(ValidW), .ReadyW(ReadyW), .RegWriteW(RegWriteW),
    .ResultSrcW(ResultSrcW), .ReadDataW(ReadDataW), .ALUResultW(ALUResultW),
    .RdW(RdW), .PCPlus4W(PCPlus4W), .ImmExtW(ImmExtW), .StallCount(StallCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic v, input logic [4:0] rd, input logic [31:0] alu);
    ValidM     = v;
    RegWriteM  = 1'b1;
    RdM        = rd;
    ALUResultM = alu;
    ResultSrcM = rd[1:0];
    ReadDataM  = 32'(rd) * 16;
    PCPlus4M   = 32'h1000 + 32'(rd) * 4;
    ImmExtM    = 32'(rd) + 100;
  endtask

  task automatic beat_is(input string tag, input logic [4:0] rd);
    check({tag, "_valid"}, ValidW, 1'b1);
    check({tag, "_rd"}, RdW, rd);
    check({tag, "_pc"}, PCPlus4W, 32'h1000 + 32'(rd) * 4);
  endtask

  initial begin
    #2;
    check("rst_valid", ValidW, 1'b0);
    check("rst_regwrite", RegWriteW, 1'b0);
    check("rst_rd", RdW, 5'd0);
    check("rst_alu", ALUResultW, 32'd0);
    check("rst_rdata", ReadDataW, 32'd0);
    check("rst_imm", ImmExtW, 32'd0);
    check("rst_cnt", StallCount, 4'd0);
    cyc(); cyc();
    #2 rst_n = 1'b1;
    cyc();
    check("rst_readym", ReadyM, 1'b1);
    // back-to-back stream with WB always ready
    ReadyW = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      put(1'b1, 5'(i), 32'(i) * 32'h111);
      cyc();
      beat_is($sformatf("stream%0d", i), 5'(i));
      check($sformatf("stream%0d_alu", i), ALUResultW, 32'(i) * 32'h111);
      check($sformatf("stream%0d_rw", i), RegWriteW, 1'b1);
    end
    put(1'b0, 5'd0, 32'd0);
    cyc();
    check("stream_drain", ValidW, 1'b0);
    check("stream_cnt", StallCount, 4'd0);
    // x0 write suppressed
    put(1'b1, 5'd0, 32'hDEADBEEF);
    cyc();
    check("x0_valid", ValidW, 1'b1);
    check("x0_alu", ALUResultW, 32'hDEADBEEF);
    check("x0_regwrite", RegWriteW, 1'b0);
    put(1'b0, 5'd0, 32'd0);
    cyc();
    check("x0_drain", ValidW, 1'b0);
    check("bubble_regwrite", RegWriteW, 1'b0);
    // stall with WB not ready: A=5, B=6, C=7
    ReadyW = 1'b0;
    put(1'b1, 5'd5, 32'hA);
    cyc();
    beat_is("stallA", 5'd5);
`ifdef MEMWB_SKID_EN
    check("stallA_readym", ReadyM, 1'b1);
`else
    check("stallA_readym", ReadyM, 1'b0);
`endif
    put(1'b1, 5'd6, 32'hB);
    cyc();
    check("stallB_readym", ReadyM, 1'b0);
    check("stallB_cnt", StallCount, 4'd1);
`ifdef MEMWB_SKID_EN
    put(1'b1, 5'd7, 32'hC);
`endif
    cyc();
    check("stallC_readym", ReadyM, 1'b0);
    beat_is("stallC_head", 5'd5);
    cyc();
    check("stall_cnt3", StallCount, 4'd3);
    ReadyW = 1'b1;
    cyc();
    beat_is("drainB", 5'd6);
    check("drainB_readym", ReadyM, 1'b1);
    put(1'b1, 5'd7, 32'hC);
    cyc();
    beat_is("drainC", 5'd7);
    check("drainC_alu", ALUResultW, 32'hC);
    put(1'b0, 5'd0, 32'd0);
    cyc();
    check("drain_empty", ValidW, 1'b0);
    check("drain_cnt", StallCount, 4'd3);
    // flush while full (skid) / holding (single entry) with a beat offered
    ReadyW = 1'b0;
    put(1'b1, 5'd8, 32'hD);
    cyc();
    put(1'b1, 5'd9, 32'hE);
    cyc();
    check("preflush_cnt", StallCount, 4'd4);
    put(1'b1, 5'd10, 32'hF);
    FlushW = 1'b1;
    cyc();
    FlushW = 1'b0;
    check("flush_valid", ValidW, 1'b0);
    check("flush_regwrite", RegWriteW, 1'b0);
    check("flush_readym", ReadyM, 1'b1);
    check("flush_cnt", StallCount, 4'd5);
    // flush coinciding with an accepted beat discards it
    ReadyW = 1'b1;
    put(1'b1, 5'd12, 32'h12);
    FlushW = 1'b1;
    cyc();
    FlushW = 1'b0;
    put(1'b0, 5'd0, 32'd0);
    check("flushacc_valid", ValidW, 1'b0);
    cyc();
    check("flushacc_never", ValidW, 1'b0);
    // counter saturation
    ReadyW = 1'b0;
    put(1'b1, 5'd11, 32'h11);
    cyc();
    put(1'b0, 5'd0, 32'd0);
    check("sat_start", StallCount, 4'd5);
    for (int i = 0; i < 21; i++) cyc();
    check("sat_cnt", StallCount, 4'd15);
    beat_is("sat_held", 5'd11);
    // asynchronous reset between edges
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", ValidW, 1'b0);
    check("arst_regwrite", RegWriteW, 1'b0);
    check("arst_cnt", StallCount, 4'd0);
    check("arst_rd", RdW, 5'd0);
    #2 rst_n = 1'b1;
    cyc();
    check("arst_readym", ReadyM, 1'b1);
    check("arst_valid_after", ValidW, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
